// File: rtl/lab1_imul_mul_arb2.sv
// lab1_imul_mul_arb2: round-robin arbiter sharing one iterative multiplier between two requesters
module lab1_imul_mul_arb2 #(
    parameter int p_cnt_nbits = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_val,
    output logic                   req0_rdy,
    input  logic [63:0]            req0_msg,
    input  logic                   req1_val,
    output logic                   req1_rdy,
    input  logic [63:0]            req1_msg,
    output logic                   resp0_val,
    input  logic                   resp0_rdy,
    output logic [31:0]            resp0_msg,
    output logic                   resp1_val,
    input  logic                   resp1_rdy,
    output logic [31:0]            resp1_msg,
    output logic                   mul_req_val,
    input  logic                   mul_req_rdy,
    output logic [63:0]            mul_req_msg,
    input  logic                   mul_resp_val,
    output logic                   mul_resp_rdy,
    input  logic [31:0]            mul_resp_msg,
    output logic                   busy,
    output logic                   owner,
    output logic [p_cnt_nbits-1:0] gnt_cnt0,
    output logic [p_cnt_nbits-1:0] gnt_cnt1
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state_q, state_d;
    logic prio_q, prio_d, owner_q, owner_d;
    logic [p_cnt_nbits-1:0] gnt_cnt0_q, gnt_cnt0_d, gnt_cnt1_q, gnt_cnt1_d;
    logic idle, any, w, grant, done;
    always_comb begin
        idle = state_q == IDLE;
        any = req0_val || req1_val;
        w = (req0_val ^ req1_val) ? req1_val : prio_q;
        mul_req_val = idle && (w ? req1_val : req0_val);
        mul_req_msg = (idle && w && req1_val) ? req1_msg : req0_msg;
        req0_rdy = idle && any && !w && mul_req_rdy;
        req1_rdy = idle && any && w && mul_req_rdy;
        resp0_val = !idle && !owner_q && mul_resp_val;
        resp1_val = !idle && owner_q && mul_resp_val;
        resp0_msg = mul_resp_msg;
        resp1_msg = mul_resp_msg;
        mul_resp_rdy = !idle && (owner_q ? resp1_rdy : resp0_rdy);
        grant = mul_req_val && mul_req_rdy;
        done = !idle && mul_resp_val && mul_resp_rdy;
        state_d = idle ? (grant ? WAIT : IDLE) : (done ? IDLE : WAIT);
        owner_d = grant ? w : owner_q;
        prio_d = grant ? !w : prio_q;
        gnt_cnt0_d = gnt_cnt0_q + p_cnt_nbits'(grant && !w);
        gnt_cnt1_d = gnt_cnt1_q + p_cnt_nbits'(grant && w);
        busy = !idle;
        owner = owner_q;
        gnt_cnt0 = gnt_cnt0_q;
        gnt_cnt1 = gnt_cnt1_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q <= 1'b0;
            owner_q <= 1'b0;
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q <= prio_d;
            owner_q <= owner_d;
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end
endmodule

// File: tb/tb_lab1_imul_mul_arb2.sv
// tb_lab1_imul_mul_arb2: directed scoreboard bench with a behavioural multiplier model
module tb_lab1_imul_mul_arb2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req0_val = 1'b0, req1_val = 1'b0;
    logic [63:0] req0_msg = '0, req1_msg = '0;
    logic        resp0_rdy = 1'b1, resp1_rdy = 1'b1;
    logic        req0_rdy, req1_rdy, resp0_val, resp1_val;
    logic [31:0] resp0_msg, resp1_msg;
    logic        mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
    logic [63:0] mul_req_msg;
    logic [31:0] mul_resp_msg;
    logic        busy, owner;
    logic [15:0] gnt_cnt0, gnt_cnt1;

    logic        n_req0_rdy, n_req1_rdy, n_resp0_val, n_resp1_val, n_mul_req_val, n_mul_resp_rdy;
    logic [31:0] n_resp0_msg, n_resp1_msg;
    logic [63:0] n_mul_req_msg;
    logic        n_busy, n_owner;
    logic [1:0]  n_gnt_cnt0, n_gnt_cnt1;

    lab1_imul_mul_arb2 u_dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
        .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
        .busy(busy), .owner(owner), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    lab1_imul_mul_arb2 #(.p_cnt_nbits(2)) u_nar (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(n_req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(n_req1_rdy), .req1_msg(req1_msg),
        .resp0_val(n_resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(n_resp0_msg),
        .resp1_val(n_resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(n_resp1_msg),
        .mul_req_val(n_mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(n_mul_req_msg),
        .mul_resp_val(mul_resp_val), .mul_resp_rdy(n_mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
        .busy(n_busy), .owner(n_owner), .gnt_cnt0(n_gnt_cnt0), .gnt_cnt1(n_gnt_cnt1)
    );

    int checks = 0;
    int errors = 0;
    int mul_lat = 3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mulf(input logic [63:0] m);
        return m[63:32] * m[31:0];
    endfunction

    // Multiplier model: one operation at a time, result after mul_lat+1 cycles
    logic        mbusy = 1'b0;
    int          mcnt = 0;
    logic [31:0] prod = '0;
    logic        mval = 1'b0;
    assign mul_req_rdy = !mbusy;
    assign mul_resp_val = mval;
    assign mul_resp_msg = prod;
    always @(posedge clk) begin
        if (reset) begin
            mbusy <= 1'b0;
            mval <= 1'b0;
            mcnt <= 0;
        end else if (!mbusy && mul_req_val) begin
            prod <= mulf(mul_req_msg);
            mbusy <= 1'b1;
            mcnt <= mul_lat;
        end else if (mbusy && !mval) begin
            if (mcnt == 0) mval <= 1'b1;
            else mcnt <= mcnt - 1;
        end else if (mval && mul_resp_rdy) begin
            mval <= 1'b0;
            mbusy <= 1'b0;
        end
    end

    logic [63:0] pq0[$], pq1[$];
    logic [32:0] sb[$];
    logic        glog[$];

    // Requester driver, scoreboard push on request handshake, pop/compare on response handshake
    always begin
        logic h0, h1;
        logic [32:0] e;
        @(negedge clk);
        h0 = !reset && req0_val && req0_rdy;
        h1 = !reset && req1_val && req1_rdy;
        if (h0) begin sb.push_back({1'b0, mulf(req0_msg)}); glog.push_back(1'b0); end
        if (h1) begin sb.push_back({1'b1, mulf(req1_msg)}); glog.push_back(1'b1); end
        if (resp0_val) begin
            chk("resp0_owner", sb.size() > 0 ? sb[0][32] : 1'b1, 0);
            if (resp0_rdy && sb.size() > 0) begin e = sb.pop_front(); chk("resp0_msg", resp0_msg, e[31:0]); end
        end
        if (resp1_val) begin
            chk("resp1_owner", sb.size() > 0 ? sb[0][32] : 1'b0, 1);
            if (resp1_rdy && sb.size() > 0) begin e = sb.pop_front(); chk("resp1_msg", resp1_msg, e[31:0]); end
        end
        @(posedge clk);
        if (h0 && pq0.size() > 0) void'(pq0.pop_front());
        if (h1 && pq1.size() > 0) void'(pq1.pop_front());
        #1;
        req0_val = !reset && pq0.size() > 0;
        req0_msg = pq0.size() > 0 ? pq0[0] : 64'd0;
        req1_val = !reset && pq1.size() > 0;
        req1_msg = pq1.size() > 0 ? pq1[0] : 64'd0;
    end

    task automatic do_reset();
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        pq0.delete(); pq1.delete(); sb.delete(); glog.delete();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((pq0.size() > 0 || pq1.size() > 0 || sb.size() > 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 2000, 1);
        @(negedge clk);
    endtask

    task automatic exp_gnt(input logic g);
        logic v;
        v = 1'bx;
        if (glog.size() > 0) v = glog.pop_front();
        chk("gnt_order", v, g);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        chk(tag, busy, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cnt0", gnt_cnt0, 0);
        chk("rst_cnt1", gnt_cnt1, 0);
        chk("rst_req0_rdy", req0_rdy, 0);
        chk("rst_mul_req_val", mul_req_val, 0);
        chk("rst_mul_resp_rdy", mul_resp_rdy, 0);
        @(posedge clk); #2 reset = 1'b0;

        // single requester
        @(negedge clk);
        pq0.push_back({32'd3, 32'd5});
        drain("single_drain");
        exp_gnt(1'b0);
        chk("single_cnt0", gnt_cnt0, 1);
        chk("single_cnt1", gnt_cnt1, 0);
        // prio now 1: contention goes to port1 first
        pq0.push_back({32'd10, 32'd10});
        pq1.push_back({32'd11, 32'd11});
        drain("prio_drain");
        exp_gnt(1'b1);
        exp_gnt(1'b0);

        // contention after reset
        do_reset();
        @(negedge clk);
        pq0.push_back({32'd7, 32'd6});
        pq1.push_back({32'd2, 32'd9});
        drain("cont_drain");
        exp_gnt(1'b0);
        exp_gnt(1'b1);
        chk("cont_cnt0", gnt_cnt0, 1);
        chk("cont_cnt1", gnt_cnt1, 1);

        // fairness under continuous contention
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pq0.push_back({32'(i + 1), 32'd100});
            pq1.push_back({32'(i + 20), 32'd3});
        end
        drain("fair_drain");
        for (int i = 0; i < 8; i++) exp_gnt(i[0]);
        chk("fair_cnt0", gnt_cnt0, 4);
        chk("fair_cnt1", gnt_cnt1, 4);
        chk("fair_narrow_cnt0", n_gnt_cnt0, 0);

        // back-pressure on resp1
        do_reset();
        @(negedge clk);
        resp1_rdy = 1'b0;
        pq1.push_back({32'hFFFF_FFFF, 32'd2});
        wait_busy("bp_busy_wait");
        pq0.push_back({32'd9, 32'd9});
        begin
            int n = 0;
            while (!mul_resp_val && n < 100) begin @(negedge clk); n++; end
            chk("bp_resp_wait", mul_resp_val, 1);
        end
        repeat (20) begin
            @(negedge clk);
            chk("bp_busy", busy, 1);
            chk("bp_req0_rdy", req0_rdy, 0);
            chk("bp_mul_resp_rdy", mul_resp_rdy, 0);
            chk("bp_owner", owner, 1);
        end
        resp1_rdy = 1'b1;
        drain("bp_drain");
        exp_gnt(1'b1);
        exp_gnt(1'b0);

        // reset while a transaction is outstanding
        do_reset();
        @(negedge clk);
        mul_lat = 10;
        pq0.push_back({32'd5, 32'd5});
        wait_busy("mid_busy_wait");
        do_reset();
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_cnt0", gnt_cnt0, 0);
        chk("mid_cnt1", gnt_cnt1, 0);
        chk("mid_resp0_val", resp0_val, 0);
        chk("mid_resp1_val", resp1_val, 0);
        mul_lat = 2;
        pq1.push_back({32'd4, 32'd4});
        pq0.push_back({32'd3, 32'd3});
        drain("mid_drain");
        exp_gnt(1'b0);
        exp_gnt(1'b1);

        // counter wrap on the 2-bit instance
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) pq0.push_back({32'(i), 32'd7});
        drain("wrap_drain");
        chk("wrap_narrow_cnt0", n_gnt_cnt0, 1);
        chk("wrap_cnt0", gnt_cnt0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
